// File: rtl/exec_control_unit.sv
// exec_control_unit
// Decode-and-execute core of the multi-cycle 32-bit CPU. It merges the main
// opcode decoder, the funct decoder and the 32-bit ALU, and it holds the 2-bit
// phase counter that paces the sequencer.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   inst                  instruction word (op/rs/rt/rd/shamt/funct/imm fields)
//   rs_data, rt_data      register-file read values (ALU operands)
//   reg_dst .. dmem_mode  datapath control lines (combinational from inst)
//   reg_write, mem_write  write enables, qualified by phase 3
//   clock_counter         instruction phase 0..3 (only state in the block)
//   alu_result, alu_zero  ALU output and its zero flag
//   branch_taken          alu_zero & branch
module exec_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_dst,
    output logic        reg_dst_r31,
    output logic        branch,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        reg_write,
    output logic        jump,
    output logic        pc_rs,
    output logic [1:0]  dmem_mode,
    output logic [1:0]  clock_counter,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    output logic        branch_taken
);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_EQ
    } alu_sel_t;

    typedef enum logic [1:0] {OP2_RT, OP2_IMM, OP2_SHAMT} op2_sel_t;

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [31:0] imm_ext_s;
    logic [31:0] op2_s;
    logic [31:0] alu_result_s;
    alu_sel_t    alu_sel_s;
    op2_sel_t    op2_sel_s;
    logic        reg_dst_s;
    logic        reg_dst_r31_s;
    logic        branch_s;
    logic        mem_to_reg_s;
    logic        jump_s;
    logic        pc_rs_s;
    logic [1:0]  dmem_mode_s;
    logic        wr_en_s;
    logic        mem_wr_en_s;
    logic [1:0]  clock_counter_r;
    logic        unused_fields_s;

    assign op_s      = inst[31:26];
    assign shamt_s   = inst[10:6];
    assign funct_s   = inst[5:0];
    assign imm_s     = inst[15:0];
    assign imm_ext_s = {{16{imm_s[15]}}, imm_s};
    // Register address fields are consumed by the register file, not here.
    assign unused_fields_s = ^inst[25:16];

    // Main opcode and funct decode: control lines, ALU function, operand-2 source.
    always_comb begin
        reg_dst_s     = 1'b0;
        reg_dst_r31_s = 1'b0;
        branch_s      = 1'b0;
        mem_to_reg_s  = 1'b0;
        jump_s        = 1'b0;
        pc_rs_s       = 1'b0;
        dmem_mode_s   = 2'b00;
        wr_en_s       = 1'b0;
        mem_wr_en_s   = 1'b0;
        alu_sel_s     = ALU_ADD;
        op2_sel_s     = OP2_RT;
        case (op_s)
            6'b000000: begin
                reg_dst_s = 1'b1;
                wr_en_s   = 1'b1;
                case (funct_s)
                    6'b100000: alu_sel_s = ALU_ADD;
                    6'b100010: alu_sel_s = ALU_SUB;
                    6'b100100: alu_sel_s = ALU_AND;
                    6'b100101: alu_sel_s = ALU_OR;
                    6'b100110: alu_sel_s = ALU_XOR;
                    6'b100111: alu_sel_s = ALU_NOR;
                    6'b101010: alu_sel_s = ALU_SLT;
                    6'b000000: begin alu_sel_s = ALU_SLL; op2_sel_s = OP2_SHAMT; end
                    6'b000010: begin alu_sel_s = ALU_SRL; op2_sel_s = OP2_SHAMT; end
                    6'b000011: begin alu_sel_s = ALU_SRA; op2_sel_s = OP2_SHAMT; end
                    6'b001000: begin pc_rs_s = 1'b1; wr_en_s = 1'b0; end
                    // Unknown funct: harmless add with no register write.
                    default:   wr_en_s = 1'b0;
                endcase
            end
            6'b001000: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_ADD; end
            6'b001100: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_AND; end
            6'b001101: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_OR;  end
            6'b001110: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_XOR; end
            6'b001010: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_SLT; end
            6'b001111: begin wr_en_s = 1'b1; op2_sel_s = OP2_IMM; alu_sel_s = ALU_LUI; end
            6'b100011, 6'b100000: begin
                wr_en_s      = 1'b1;
                mem_to_reg_s = 1'b1;
                op2_sel_s    = OP2_IMM;
                dmem_mode_s  = (op_s == 6'b100000) ? 2'b01 : 2'b00;
            end
            6'b101011, 6'b101000: begin
                mem_wr_en_s = 1'b1;
                op2_sel_s   = OP2_IMM;
                dmem_mode_s = (op_s == 6'b101000) ? 2'b01 : 2'b00;
            end
            6'b000100: begin branch_s = 1'b1; alu_sel_s = ALU_SUB; end
            // bne inverts the sense so that alu_zero still means "take branch".
            6'b000101: begin branch_s = 1'b1; alu_sel_s = ALU_EQ; end
            6'b000010: jump_s = 1'b1;
            6'b000011: begin jump_s = 1'b1; reg_dst_r31_s = 1'b1; wr_en_s = 1'b1; end
            // Undefined opcode: every control stays low, ALU adds (NOP).
            default:   alu_sel_s = ALU_ADD;
        endcase
    end

    // Operand-2 multiplexer.
    always_comb begin
        case (op2_sel_s)
            OP2_SHAMT: op2_s = {27'd0, shamt_s};
            OP2_IMM:   op2_s = imm_ext_s;
            default:   op2_s = rt_data;
        endcase
    end

    // 32-bit ALU.
    always_comb begin
        case (alu_sel_s)
            ALU_ADD: alu_result_s = rs_data + op2_s;
            ALU_SUB: alu_result_s = rs_data - op2_s;
            ALU_AND: alu_result_s = rs_data & op2_s;
            ALU_OR:  alu_result_s = rs_data | op2_s;
            ALU_XOR: alu_result_s = rs_data ^ op2_s;
            ALU_NOR: alu_result_s = ~(rs_data | op2_s);
            ALU_SLT: alu_result_s = ($signed(rs_data) < $signed(op2_s)) ? 32'd1 : 32'd0;
            ALU_SLL: alu_result_s = rs_data << op2_s[4:0];
            ALU_SRL: alu_result_s = rs_data >> op2_s[4:0];
            ALU_SRA: alu_result_s = $unsigned($signed(rs_data) >>> op2_s[4:0]);
            ALU_LUI: alu_result_s = {imm_s, 16'd0};
            ALU_EQ:  alu_result_s = (rs_data == op2_s) ? 32'd1 : 32'd0;
            default: alu_result_s = rs_data + op2_s;
        endcase
    end

    // Free-running phase counter; reset forces phase 0 immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clock_counter_r <= 2'd0;
        end else begin
            clock_counter_r <= clock_counter_r + 2'd1;
        end
    end

    assign reg_dst       = reg_dst_s;
    assign reg_dst_r31   = reg_dst_r31_s;
    assign branch        = branch_s;
    assign mem_to_reg    = mem_to_reg_s;
    assign jump          = jump_s;
    assign pc_rs         = pc_rs_s;
    assign dmem_mode     = dmem_mode_s;
    assign clock_counter = clock_counter_r;
    // One write pulse per instruction, in the last phase.
    assign reg_write     = wr_en_s & (clock_counter_r == 2'd3);
    assign mem_write     = mem_wr_en_s & (clock_counter_r == 2'd3);
    assign alu_result    = alu_result_s;
    assign alu_zero      = (alu_result_s == 32'd0);
    assign branch_taken  = alu_zero & branch_s;

endmodule

// File: tb/tb_exec_control_unit.sv
// Directed testbench for exec_control_unit.
module tb_exec_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        reg_dst, reg_dst_r31, branch, mem_to_reg, mem_write, reg_write;
    logic        jump, pc_rs, alu_zero, branch_taken;
    logic [1:0]  dmem_mode, clock_counter;
    logic [31:0] alu_result;
    logic [7:0]  ctrl;
    logic [1:0]  phase_m;
    int          total = 0;
    int          bad = 0;

    exec_control_unit dut (
        .clk(clk), .reset(reset), .inst(inst), .rs_data(rs_data), .rt_data(rt_data),
        .reg_dst(reg_dst), .reg_dst_r31(reg_dst_r31), .branch(branch),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .reg_write(reg_write),
        .jump(jump), .pc_rs(pc_rs), .dmem_mode(dmem_mode),
        .clock_counter(clock_counter), .alu_result(alu_result),
        .alu_zero(alu_zero), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    // {reg_dst, reg_dst_r31, branch, mem_to_reg, jump, pc_rs, dmem_mode}
    assign ctrl = {reg_dst, reg_dst_r31, branch, mem_to_reg, jump, pc_rs, dmem_mode};

    // Reference phase: 0 on reset, +1 per rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) phase_m <= 2'd0;
        else       phase_m <= phase_m + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'b000000, 5'd1, 5'd2, 5'd3, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Drive new inputs just after a rising edge, return at the following falling edge.
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        inst = i;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
    endtask

    // Walk all four phases checking the phase-qualified write enables.
    task automatic walk(input string tag, input logic rw, input logic mw);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_reg_write"}, {31'd0, reg_write}, {31'd0, rw && (phase_m == 2'd3)});
            chk({tag, "_mem_write"}, {31'd0, mem_write}, {31'd0, mw && (phase_m == 2'd3)});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [1:0] seq_exp [4];
        seq_exp[0] = 2'd1; seq_exp[1] = 2'd2; seq_exp[2] = 2'd3; seq_exp[3] = 2'd0;

        // Reset and counter sequence
        inst = rtype(6'b100000, 5'd0);
        repeat (3) @(negedge clk);
        chk("cnt_in_reset", {30'd0, clock_counter}, 32'd0);
        chk("rw_in_reset", {31'd0, reg_write}, 32'd0);
        reset = 1'b0;
        chk("cnt_after_release", {30'd0, clock_counter}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cnt_seq", {30'd0, clock_counter}, {30'd0, seq_exp[k]});
        end
        @(negedge clk);
        @(negedge clk);
        chk("cnt_phase2", {30'd0, clock_counter}, 32'd2);
        reset = 1'b1;
        #1;
        chk("cnt_async_reset", {30'd0, clock_counter}, 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("cnt_resume", {30'd0, clock_counter}, 32'd1);

        // R-type arithmetic/logic, rs=5 rt=7
        apply(rtype(6'b100000, 5'd0), 32'd5, 32'd7);
        chk("add", alu_result, 32'd12);
        chk("add_ctrl", {24'd0, ctrl}, 32'h80);
        walk("add", 1'b1, 1'b0);
        apply(rtype(6'b100010, 5'd0), 32'd5, 32'd7);
        chk("sub", alu_result, 32'hFFFF_FFFE);
        chk("sub_zero", {31'd0, alu_zero}, 32'd0);
        apply(rtype(6'b101010, 5'd0), 32'd5, 32'd7);
        chk("slt", alu_result, 32'd1);
        apply(rtype(6'b101010, 5'd0), 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg", alu_result, 32'd1);
        apply(rtype(6'b101010, 5'd0), 32'd7, 32'd5);
        chk("slt_false", alu_result, 32'd0);
        apply(rtype(6'b100100, 5'd0), 32'd5, 32'd7);
        chk("and", alu_result, 32'd5);
        apply(rtype(6'b100101, 5'd0), 32'd5, 32'd7);
        chk("or", alu_result, 32'd7);
        apply(rtype(6'b100110, 5'd0), 32'd5, 32'd7);
        chk("xor", alu_result, 32'd2);
        apply(rtype(6'b100111, 5'd0), 32'd5, 32'd7);
        chk("nor", alu_result, 32'hFFFF_FFF8);

        // Shifts
        apply(rtype(6'b000011, 5'd4), 32'h8000_0000, 32'd3);
        chk("sra", alu_result, 32'hF800_0000);
        apply(rtype(6'b000010, 5'd4), 32'h8000_0000, 32'd3);
        chk("srl", alu_result, 32'h0800_0000);
        apply(rtype(6'b000000, 5'd4), 32'h8000_0001, 32'd3);
        chk("sll", alu_result, 32'h0000_0010);

        // Immediates
        apply(itype(6'b001000, 16'hFFFF), 32'd1, 32'd99);
        chk("addi", alu_result, 32'd0);
        chk("addi_zero", {31'd0, alu_zero}, 32'd1);
        chk("addi_ctrl", {24'd0, ctrl}, 32'h00);
        walk("addi", 1'b1, 1'b0);
        apply(itype(6'b001111, 16'h1234), 32'hDEAD_BEEF, 32'd0);
        chk("lui", alu_result, 32'h1234_0000);
        apply(itype(6'b001100, 16'h8000), 32'hFFFF_FFFF, 32'd0);
        chk("andi_sext", alu_result, 32'hFFFF_8000);
        apply(itype(6'b001101, 16'h8001), 32'd0, 32'd0);
        chk("ori_sext", alu_result, 32'hFFFF_8001);
        apply(itype(6'b001110, 16'hFFFF), 32'h0000_000F, 32'd0);
        chk("xori_sext", alu_result, 32'hFFFF_FFF0);
        apply(itype(6'b001010, 16'h0000), 32'hFFFF_FFFF, 32'd0);
        chk("slti", alu_result, 32'd1);

        // Memory
        apply(itype(6'b100011, 16'h0004), 32'h10, 32'd0);
        chk("lw_addr", alu_result, 32'h14);
        chk("lw_ctrl", {24'd0, ctrl}, 32'h10);
        walk("lw", 1'b1, 1'b0);
        apply(itype(6'b100000, 16'h0001), 32'h10, 32'd0);
        chk("lb_ctrl", {24'd0, ctrl}, 32'h11);
        apply(itype(6'b101000, 16'hFFFC), 32'h100, 32'd0);
        chk("sb_addr", alu_result, 32'hFC);
        chk("sb_ctrl", {24'd0, ctrl}, 32'h01);
        walk("sb", 1'b0, 1'b1);
        apply(itype(6'b101011, 16'h0008), 32'h20, 32'd0);
        chk("sw_ctrl", {24'd0, ctrl}, 32'h00);
        walk("sw", 1'b0, 1'b1);

        // Branches
        apply(itype(6'b000100, 16'h0003), 32'd9, 32'd9);
        chk("beq_eq_taken", {31'd0, branch_taken}, 32'd1);
        chk("beq_ctrl", {24'd0, ctrl}, 32'h20);
        walk("beq", 1'b0, 1'b0);
        apply(itype(6'b000101, 16'h0003), 32'd9, 32'd9);
        chk("bne_eq_taken", {31'd0, branch_taken}, 32'd0);
        apply(itype(6'b000100, 16'h0003), 32'd9, 32'd8);
        chk("beq_ne_taken", {31'd0, branch_taken}, 32'd0);
        apply(itype(6'b000101, 16'h0003), 32'd9, 32'd8);
        chk("bne_ne_taken", {31'd0, branch_taken}, 32'd1);

        // Jumps
        apply({6'b000011, 26'h0000100}, 32'd1, 32'd2);
        chk("jal_ctrl", {24'd0, ctrl}, 32'h48);
        walk("jal", 1'b1, 1'b0);
        apply({6'b000010, 26'h0000100}, 32'd1, 32'd2);
        chk("j_ctrl", {24'd0, ctrl}, 32'h08);
        apply(rtype(6'b001000, 5'd0), 32'h400, 32'd0);
        chk("jr_ctrl", {24'd0, ctrl}, 32'h84);
        walk("jr", 1'b0, 1'b0);

        // Unknown funct and undefined opcode
        apply(rtype(6'b111111, 5'd0), 32'd5, 32'd7);
        chk("badfunct_add", alu_result, 32'd12);
        walk("badfunct", 1'b0, 1'b0);
        apply({6'b111111, 26'h3FF_FFFF}, 32'd5, 32'd7);
        chk("undef_ctrl", {24'd0, ctrl}, 32'h00);
        chk("undef_add", alu_result, 32'd12);
        chk("undef_taken", {31'd0, branch_taken}, 32'd0);
        walk("undef", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
